// File: rtl/ram_mb_if.sv
// Request/response bundle for ram_mb: one read port and one byte-masked write port.
// The controller side uses the master modport, the RAM uses slave.
interface ram_mb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                         ready;
  logic                         read_req;
  logic [ADDR_WIDTH-1:0]        read_addr;
  logic signed [DATA_WIDTH-1:0] read_data;
  logic                         read_valid;
  logic                         write_req;
  logic [ADDR_WIDTH-1:0]        write_addr;
  logic [DATA_WIDTH-1:0]        write_data;
  logic [MASK_WIDTH-1:0]        write_mask;

  modport master (
    input  ready, read_data, read_valid,
    output read_req, read_addr, write_req, write_addr, write_data, write_mask
  );

  modport slave (
    output ready, read_data, read_valid,
    input  read_req, read_addr, write_req, write_addr, write_data, write_mask
  );
endinterface

// File: rtl/ram_mb.sv
// Byte-maskable scratch RAM with a post-reset clear engine and 0/1/2-cycle read latency.
// Define RAM_BYPASS_EN to forward same-cycle same-address write bytes into the read result.
module ram_mb #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    READ_LATENCY = 1,   // 0, 1 or 2
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic    clk,
  input  logic    reset,
  ram_mb_if.slave bus
);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready, rd_acc, wr_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_mask;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;

  assign ready     = (state_q == S_RUN);
  assign rd_acc    = bus.read_req & ready;
  assign wr_acc    = bus.write_req & ready;
  assign bus.ready = ready;

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = wr_acc;
    mem_addr  = bus.write_addr;
    mem_wdata = bus.write_data;
    mem_mask  = bus.write_mask;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = INIT_VALUE;
      mem_mask  = '1;
      cnt_d     = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == '1) state_d = S_RUN;
    end
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the array has no reset; the init engine clears it word by word instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (mem_mask[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[bus.read_addr];
`ifdef RAM_BYPASS_EN
    if (wr_acc && (bus.write_addr == bus.read_addr)) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (bus.write_mask[i]) rd_word[8*i +: 8] = bus.write_data[8*i +: 8];
      end
    end
`endif
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign bus.read_data  = rd_word;
    assign bus.read_valid = rd_acc;
  end else begin : g_lat_reg
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic                  rv1_q;

    always_comb begin
      rd1_d = rd1_q;
      if (rd_acc) rd1_d = rd_word;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd1_q <= '0;
        rv1_q <= 1'b0;
      end else begin
        rd1_q <= rd1_d;
        rv1_q <= rd_acc;
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      assign bus.read_data  = rd1_q;
      assign bus.read_valid = rv1_q;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
      logic                  rv2_q;

      // Second stage only advances when the first stage holds a fresh result.
      always_comb begin
        rd2_d = rd2_q;
        if (rv1_q) rd2_d = rd1_q;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd2_q <= '0;
          rv2_q <= 1'b0;
        end else begin
          rd2_q <= rd2_d;
          rv2_q <= rv1_q;
        end
      end

      assign bus.read_data  = rd2_q;
      assign bus.read_valid = rv2_q;
    end
  end
endmodule

// File: tb/tb_ram_mb.sv
// Drives three ram_mb instances (read latency 0, 1, 2) with identical traffic and
// checks each against a shadow-memory scoreboard keyed by the expected arrival cycle.
module tb_ram_mb;
  localparam int              DW    = 32;
  localparam int              AW    = 8;
  localparam int              MW    = DW / 8;
  localparam int              DEPTH = 1 << AW;
  localparam logic [DW-1:0]   INIT  = '0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          read_req, write_req;
  logic [AW-1:0] read_addr, write_addr;
  logic [DW-1:0] write_data;
  logic [MW-1:0] write_mask;

  logic          rdy [3];
  logic          rv  [3];
  logic [DW-1:0] rd  [3];

  logic [DW-1:0] model [DEPTH];
  exp_t          sb [3][$];
  logic          tb_ready;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    ram_mb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    assign bus.read_req   = read_req;
    assign bus.read_addr  = read_addr;
    assign bus.write_req  = write_req;
    assign bus.write_addr = write_addr;
    assign bus.write_data = write_data;
    assign bus.write_mask = write_mask;
    assign rdy[g] = bus.ready;
    assign rv[g]  = bus.read_valid;
    assign rd[g]  = bus.read_data;

    ram_mb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(g), .INIT_VALUE(INIT)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [MW-1:0] wm);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < MW; i++) if (wm[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Every cycle, each lane's valid must match whether a result is due now.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      logic ev;
      exp_t e;
      ev = (sb[g].size() > 0) && (sb[g][0].due == cyc);
      check($sformatf("valid_lat%0d_cyc%0d", g, cyc), DW'(rv[g]), DW'(ev));
      if (ev) begin
        e = sb[g].pop_front();
        check($sformatf("data_lat%0d_cyc%0d", g, cyc), rd[g], e.data);
      end
    end
  end

  task automatic step(input logic rq, input logic [AW-1:0] ra, input logic wq,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    exp_t e;
    @(posedge clk); #1;
    read_req = rq; read_addr = ra;
    write_req = wq; write_addr = wa; write_data = wd; write_mask = wm;
    if (tb_ready) begin
      if (rq) begin
        e.data = model[ra];
`ifdef RAM_BYPASS_EN
        if (wq && (wa == ra)) e.data = merge(model[ra], wd, wm);
`endif
        for (int g = 0; g < 3; g++) begin
          e.due = cyc + g;
          sb[g].push_back(e);
        end
      end
      if (wq) model[wa] = merge(model[wa], wd, wm);
    end
  endtask

  task automatic rd_step(input logic [AW-1:0] a);
    step(1'b1, a, 1'b0, '0, '0, '0);
  endtask

  task automatic wr_step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    step(1'b0, '0, 1'b1, a, d, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    read_req = 1'b0; write_req = 1'b0;
    tb_ready = 1'b0;
    for (int g = 0; g < 3; g++) sb[g].delete();
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
  endtask

  // Release reset and count cycles until ready; optionally hammer addr 7 with writes meanwhile.
  task automatic release_and_init(input logic wr_during_init);
    int n;
    @(posedge clk); #1;
    reset = 1'b1;
    write_req = wr_during_init; write_addr = 8'd7; write_data = 32'hDEADBEEF; write_mask = '1;
    n = 0;
    while (!rdy[0] && n < DEPTH + 8) begin
      @(posedge clk); #1;
      n++;
    end
    write_req = 1'b0;
    check("init_cycles", DW'(n), DW'(DEPTH));
    for (int g = 0; g < 3; g++) check($sformatf("ready_after_init_lat%0d", g), DW'(rdy[g]), 1);
    tb_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tb_ready = 1'b0;
    read_req = 1'b0; read_addr = '0;
    write_req = 1'b0; write_addr = '0; write_data = '0; write_mask = '0;
    #1 assert_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_ready_lat%0d", g), DW'(rdy[g]), 0);
      check($sformatf("reset_valid_lat%0d", g), DW'(rv[g]), 0);
    end
    release_and_init(1'b0);

    rd_step(8'd0); rd_step(8'd5); rd_step(8'(DEPTH - 1));
    idle(1);

    wr_step(8'd7, 32'h11223344, 4'b1111);
    rd_step(8'd7);
    wr_step(8'd7, 32'hAABBCCDD, 4'b0101);
    rd_step(8'd7);
    wr_step(8'd8, 32'hFFFFFFFF, 4'b0000);
    rd_step(8'd8);

    step(1'b1, 8'd9, 1'b1, 8'd9, 32'h00000055, 4'b1111);
    rd_step(8'd9);
    step(1'b1, 8'd10, 1'b1, 8'd10, 32'hCAFEF00D, 4'b0110);
    rd_step(8'd10);
    step(1'b1, 8'd11, 1'b1, 8'd12, 32'h12345678, 4'b1111);
    rd_step(8'd12);

    wr_step(8'd1, 32'h0101A001, 4'b1111);
    wr_step(8'd2, 32'h0202B002, 4'b1111);
    wr_step(8'd3, 32'h0303C003, 4'b1111);
    rd_step(8'd1); rd_step(8'd2); rd_step(8'd3);
    idle(3);

    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    idle(3);

    // Reset while reads are still in flight in the pipelined lanes.
    rd_step(8'd4);
    @(posedge clk); #1;
    assert_reset();
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("midread_valid_lat%0d", g), DW'(rv[g]), 0);
      check($sformatf("midread_ready_lat%0d", g), DW'(rdy[g]), 0);
    end
    repeat (2) @(posedge clk);
    release_and_init(1'b1);
    rd_step(8'd7); rd_step(8'd4);
    idle(3);

    // Reset again partway through the init sweep.
    @(posedge clk); #1;
    assert_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    assert_reset();
    #1;
    for (int g = 0; g < 3; g++) check($sformatf("midinit_ready_lat%0d", g), DW'(rdy[g]), 0);
    repeat (3) @(posedge clk);
    release_and_init(1'b1);
    rd_step(8'd7); rd_step(8'd0); rd_step(8'(DEPTH - 1));
    idle(4);

    for (int g = 0; g < 3; g++) check($sformatf("drain_lat%0d", g), DW'(sb[g].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
